// File: rtl/dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_ctrl : MEM-stage bus to single-port byte-enabled SRAM (1-cycle read). |
// | Optional misalignment trap: define DMEM_CTRL_MISALIGN_TRAP_EN.             |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module dmem_ctrl #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dad,
  input  logic [31:0]       ddt_in,
  output logic [31:0]       ddt_out,
  output logic              ddt_oe,
  input  logic              mreq,
  input  logic              write,
  input  logic [1:0]        size,
  output logic              ackd_n,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

  localparam logic [1:0] c_SZ_HALF   = 2'b01;
  localparam logic [1:0] c_SZ_BYTE   = 2'b10;
  localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [3:0]  r_be;
  logic        r_trap;

  logic [3:0]  w_be_in;
  logic [31:0] w_wdata_in;
  logic        w_trap_in;
  logic [31:0] w_rdata;

  always_comb begin
    w_be_in    = 4'b1111;
    w_wdata_in = ddt_in;
    case (size)
      c_SZ_HALF: begin
        w_be_in    = dad[1] ? 4'b1100 : 4'b0011;
        w_wdata_in = {2{ddt_in[15:0]}};
      end
      c_SZ_BYTE: begin
        w_be_in    = 4'b0001 << dad[1:0];
        w_wdata_in = {4{ddt_in[7:0]}};
      end
      default: ;
    endcase
  end

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  assign w_trap_in = ((size == c_SZ_HALF) && dad[0]) ||
                     ((size != c_SZ_HALF) && (size != c_SZ_BYTE) && (dad[1:0] != 2'b00));
`else
  assign w_trap_in = 1'b0;
`endif

  generate
    if (ADDR_W < 30) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^dad[31:ADDR_W+2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_be      <= 4'b0000;
      r_trap    <= 1'b0;
      ackd_n    <= 1'b1;
      ddt_oe    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      ackd_n <= 1'b1;
      ddt_oe <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (mreq) begin
            r_write   <= write;
            r_size    <= size;
            r_lane    <= dad[1:0];
            r_be      <= w_be_in;
            r_trap    <= w_trap_in;
            mem_addr  <= dad[ADDR_W+1:2];
            mem_wdata <= w_wdata_in;
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= c_WAIT_LOAD;
            end else begin
              // Zero wait states: SRAM strobes come straight from the request.
              r_state <= S_ACCESS;
              mem_en  <= ~w_trap_in;
              mem_we  <= write & ~w_trap_in;
              mem_be  <= w_trap_in ? 4'b0000 : w_be_in;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ACCESS;
            mem_en  <= ~r_trap;
            mem_we  <= r_write & ~r_trap;
            mem_be  <= r_trap ? 4'b0000 : r_be;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          ackd_n  <= 1'b0;
          ddt_oe  <= ~r_write;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_ACCESS) && r_trap) begin
      r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // SRAM data arrives during RESP, so extraction is steered by latched state only.
  always_comb begin
    w_rdata = 32'd0;
    if ((r_state == S_RESP) && !r_write && !r_trap) begin
      case (r_size)
        c_SZ_HALF: w_rdata = {16'd0, r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
        c_SZ_BYTE: w_rdata = {24'd0, mem_rdata[{r_lane, 3'b000} +: 8]};
        default:   w_rdata = mem_rdata;
      endcase
    end
  end

  assign ddt_out = w_rdata;

endmodule
`default_nettype wire
